// File: rtl/pulse_param_pkg.sv
// Shared constants and types for the pulse-parameter command parser and its register bank.
package pulse_param_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ATT_W  = 7;
  localparam int unsigned BLK_W  = 8;

  localparam logic [BYTE_W-1:0] OP_PERIOD    = 8'h01;
  localparam logic [BYTE_W-1:0] OP_P1WIDTH   = 8'h02;
  localparam logic [BYTE_W-1:0] OP_DELAY     = 8'h03;
  localparam logic [BYTE_W-1:0] OP_P2WIDTH   = 8'h04;
  localparam logic [BYTE_W-1:0] OP_PRE_ATT   = 8'h05;
  localparam logic [BYTE_W-1:0] OP_POST_ATT  = 8'h06;
  localparam logic [BYTE_W-1:0] OP_PBLOCK    = 8'h07;
  localparam logic [BYTE_W-1:0] OP_PBLOCK_OFF = 8'h08;
  localparam logic [BYTE_W-1:0] OP_FLAGS     = 8'h09;
  localparam logic [BYTE_W-1:0] OP_APPLY     = 8'h0F;

  localparam logic [BYTE_W-1:0] RSP_BADCK   = 8'hEE;
  localparam logic [BYTE_W-1:0] RSP_BADOP   = 8'hEF;
  localparam logic [BYTE_W-1:0] RSP_TIMEOUT = 8'hED;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_PAYLOAD = 2'd1;
  localparam state_t ST_CSUM    = 2'd2;
  localparam state_t ST_RESP    = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] period;
    logic [DATA_W-1:0] p1width;
    logic [DATA_W-1:0] delay;
    logic [DATA_W-1:0] p2width;
    logic [DATA_W-1:0] pulse_block_off;
    logic [ATT_W-1:0]  pre_att;
    logic [ATT_W-1:0]  post_att;
    logic [BLK_W-1:0]  pulse_block;
    logic              pump;
    logic              block;
  } params_t;

  localparam params_t PARAMS_RST = '0;

  function automatic logic op_known(input logic [BYTE_W-1:0] op);
    return ((op >= OP_PERIOD) && (op <= OP_FLAGS)) || (op == OP_APPLY);
  endfunction

endpackage

// File: rtl/pulse_param_bank.sv
// Shadow and live pulse-parameter registers; APPLY copies every shadow field to live at once.
module pulse_param_bank
  import pulse_param_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [BYTE_W-1:0] i_op,
  input  logic [DATA_W-1:0] i_payload,
  input  logic              i_apply,
  output logic [DATA_W-1:0] o_period,
  output logic [DATA_W-1:0] o_p1width,
  output logic [DATA_W-1:0] o_delay,
  output logic [DATA_W-1:0] o_p2width,
  output logic [DATA_W-1:0] o_pulse_block_off,
  output logic [ATT_W-1:0]  o_pre_att,
  output logic [ATT_W-1:0]  o_post_att,
  output logic [BLK_W-1:0]  o_pulse_block,
  output logic              o_pump,
  output logic              o_block,
  output logic              o_update
);

  params_t r_shadow;
  params_t r_live;
  logic    r_update;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= PARAMS_RST;
    end else if (i_wr_en) begin
      case (i_op)
        OP_PERIOD:     r_shadow.period          <= i_payload;
        OP_P1WIDTH:    r_shadow.p1width         <= i_payload;
        OP_DELAY:      r_shadow.delay           <= i_payload;
        OP_P2WIDTH:    r_shadow.p2width         <= i_payload;
        OP_PRE_ATT:    r_shadow.pre_att         <= i_payload[ATT_W-1:0];
        OP_POST_ATT:   r_shadow.post_att        <= i_payload[ATT_W-1:0];
        OP_PBLOCK:     r_shadow.pulse_block     <= i_payload[BLK_W-1:0];
        OP_PBLOCK_OFF: r_shadow.pulse_block_off <= i_payload;
        OP_FLAGS: begin
          r_shadow.pump  <= i_payload[0];
          r_shadow.block <= i_payload[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_live   <= PARAMS_RST;
      r_update <= 1'b0;
    end else begin
      r_update <= i_apply;
      if (i_apply) r_live <= r_shadow;
    end
  end

  assign o_period          = r_live.period;
  assign o_p1width         = r_live.p1width;
  assign o_delay           = r_live.delay;
  assign o_p2width         = r_live.p2width;
  assign o_pulse_block_off = r_live.pulse_block_off;
  assign o_pre_att         = r_live.pre_att;
  assign o_post_att        = r_live.post_att;
  assign o_pulse_block     = r_live.pulse_block;
  assign o_pump            = r_live.pump;
  assign o_block           = r_live.block;
  assign o_update          = r_update;

endmodule

// File: rtl/pulse_param_loader.sv
// Host byte-stream command parser: frames OP+4 payload bytes+XOR checksum, one response byte per frame.
module pulse_param_loader
  import pulse_param_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] p1width,
  output logic [DATA_W-1:0] delay,
  output logic [DATA_W-1:0] p2width,
  output logic [DATA_W-1:0] pulse_block_off,
  output logic [ATT_W-1:0]  pre_att,
  output logic [ATT_W-1:0]  post_att,
  output logic [BLK_W-1:0]  pulse_block,
  output logic              pump,
  output logic              block,
  output logic              update
);

  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            r_state,   w_state;
  logic [BYTE_W-1:0] r_op,      w_op;
  logic [DATA_W-1:0] r_payload, w_payload;
  logic [BYTE_W-1:0] r_xor,     w_xor;
  logic [1:0]        r_bcnt,    w_bcnt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data;
  logic              r_tx_valid, w_tx_valid;
  logic              w_wr_en;
  logic              w_apply;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_payload  <= '0;
      r_xor      <= '0;
      r_bcnt     <= '0;
      r_cnt      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_op       <= w_op;
      r_payload  <= w_payload;
      r_xor      <= w_xor;
      r_bcnt     <= w_bcnt;
      r_cnt      <= w_cnt;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
    end
  end

  // An arriving byte wins over a timeout expiring in the same cycle.
  always_comb begin
    w_state    = r_state;
    w_op       = r_op;
    w_payload  = r_payload;
    w_xor      = r_xor;
    w_bcnt     = r_bcnt;
    w_cnt      = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_wr_en    = 1'b0;
    w_apply    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt = '0;
        if (rx_valid) begin
          w_op    = rx_data;
          w_xor   = rx_data;
          w_bcnt  = '0;
          w_state = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          w_payload = {r_payload[DATA_W-BYTE_W-1:0], rx_data};
          w_xor     = r_xor ^ rx_data;
          w_bcnt    = r_bcnt + 2'd1;
          w_cnt     = '0;
          if (r_bcnt == 2'd3) w_state = ST_CSUM;
        end else if (r_cnt == CNT_LAST) begin
          w_tx_data  = RSP_TIMEOUT;
          w_tx_valid = 1'b1;
          w_state    = ST_RESP;
        end
      end
      ST_CSUM: begin
        if (rx_valid) begin
          w_tx_valid = 1'b1;
          w_state    = ST_RESP;
          if (rx_data != r_xor) begin
            w_tx_data = RSP_BADCK;
          end else if (!op_known(r_op)) begin
            w_tx_data = RSP_BADOP;
          end else begin
            w_tx_data = r_op;
            w_wr_en   = (r_op != OP_APPLY);
            w_apply   = (r_op == OP_APPLY);
          end
        end else if (r_cnt == CNT_LAST) begin
          w_tx_data  = RSP_TIMEOUT;
          w_tx_valid = 1'b1;
          w_state    = ST_RESP;
        end
      end
      ST_RESP: begin
        w_cnt = '0;
        if (tx_ready) begin
          w_tx_valid = 1'b0;
          w_state    = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;

  pulse_param_bank u_bank (
    .clk               (clk),
    .reset             (reset),
    .i_wr_en           (w_wr_en),
    .i_op              (r_op),
    .i_payload         (r_payload),
    .i_apply           (w_apply),
    .o_period          (period),
    .o_p1width         (p1width),
    .o_delay           (delay),
    .o_p2width         (p2width),
    .o_pulse_block_off (pulse_block_off),
    .o_pre_att         (pre_att),
    .o_post_att        (post_att),
    .o_pulse_block     (pulse_block),
    .o_pump            (pump),
    .o_block           (block),
    .o_update          (update)
  );

endmodule

// File: tb/tb_pulse_param_loader.sv
// Scenario bench for pulse_param_loader; response bytes are checked against a queue of expected codes.
module tb_pulse_param_loader;

  localparam int unsigned TO = 100;
  localparam logic [47:0] APPLY_FR = 48'h0F_00_00_00_00_0F;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] period, p1width, delay, p2width, pulse_block_off;
  logic [6:0]  pre_att, post_att;
  logic [7:0]  pulse_block;
  logic        pump, block, update;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_param_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
    .pulse_block_off(pulse_block_off), .pre_att(pre_att), .post_att(post_att),
    .pulse_block(pulse_block), .pump(pump), .block(block), .update(update)
  );

  // Response scoreboard: each accepted byte must match the oldest expected code.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!reset && tx_valid && tx_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_unexpected: got %02h, expected no response", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          n_fail++;
          $display("FAIL tx_data: got %02h, expected %02h", tx_data, exp_b);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] fr, input logic [7:0] exp_rsp);
    exp_q.push_back(exp_rsp);
    for (int i = 5; i >= 0; i--) send_byte(fr[i*8 +: 8]);
  endtask

  task automatic wait_resp();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL resp_wait: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({period, p1width, delay, p2width, pulse_block_off, pre_att, post_att, pulse_block, pump, block} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got nonzero live fields period=%h pre_att=%h, expected all 0", period, pre_att);
    end
    n_tests++;
    if ({tx_valid, update} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got tx_valid=%b update=%b, expected 0 0", tx_valid, update);
    end
  endtask

  task automatic test_period_apply();
    send_frame(48'h01_00_00_30_D4_E5, 8'h01);
    @(negedge clk);
    n_tests++;
    if (period !== 32'h0 || update !== 1'b0 || tx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL shadow_only: got period=%h update=%b tx_valid=%b, expected 0 0 1", period, update, tx_valid);
    end
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (period !== 32'h30D4 || update !== 1'b1) begin
      n_fail++;
      $display("FAIL apply_period: got period=%h update=%b, expected 000030d4 1", period, update);
    end
    n_tests++;
    if ({p1width, delay, p2width, pulse_block_off, pre_att, post_att, pulse_block, pump, block} !== '0) begin
      n_fail++;
      $display("FAIL apply_others: got p1width=%h pre_att=%h, expected all other fields 0", p1width, pre_att);
    end
    @(negedge clk);
    n_tests++;
    if (update !== 1'b0) begin
      n_fail++;
      $display("FAIL update_pulse: got update=%b one cycle later, expected 0", update);
    end
    wait_resp();
  endtask

  task automatic test_narrow();
    send_frame(48'h05_00_00_00_FF_FA, 8'h05);
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (pre_att !== 7'h7F || period !== 32'h30D4) begin
      n_fail++;
      $display("FAIL pre_att: got pre_att=%h period=%h, expected 7f 000030d4", pre_att, period);
    end
    wait_resp();
  endtask

  task automatic test_bad_ck();
    send_frame(48'h02_00_00_00_10_00, 8'hEE);
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (p1width !== 32'h0) begin
      n_fail++;
      $display("FAIL bad_ck_p1width: got %h, expected 0", p1width);
    end
    wait_resp();
  endtask

  task automatic test_bad_op();
    send_frame(48'h22_00_00_00_00_22, 8'hEF);
    @(negedge clk);
    n_tests++;
    if (update !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_op_update: got update=%b, expected 0", update);
    end
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (period !== 32'h30D4 || pre_att !== 7'h7F || p1width !== 32'h0 || pulse_block !== 8'h0) begin
      n_fail++;
      $display("FAIL bad_op_regs: got period=%h pre_att=%h p1width=%h pblk=%h, expected 30d4 7f 0 0",
               period, pre_att, p1width, pulse_block);
    end
    wait_resp();
  endtask

  task automatic test_timeout();
    logic early = 1'b0;
    tx_ready = 1'b0;
    exp_q.push_back(8'hED);
    send_byte(8'h09);
    send_byte(8'h00);
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) early = 1'b1;
    end
    n_tests++;
    if (early) begin
      n_fail++;
      $display("FAIL timeout_early: got tx_valid=1 before T+TIMEOUT+1, expected 0");
    end
    @(negedge clk);
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hED) begin
      n_fail++;
      $display("FAIL timeout_rsp: got tx_valid=%b tx_data=%02h, expected 1 ed", tx_valid, tx_data);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_resp();
    send_frame(48'h09_00_00_00_03_0A, 8'h09);
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (pump !== 1'b1 || block !== 1'b1) begin
      n_fail++;
      $display("FAIL flags: got pump=%b block=%b, expected 1 1", pump, block);
    end
    wait_resp();
  endtask

  task automatic test_back_to_back();
    send_frame(48'h07_00_00_01_A5_A3, 8'h07);
    send_frame(48'h03_00_00_01_00_02, 8'h03);
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (update !== 1'b1 || pulse_block !== 8'hA5 || delay !== 32'h100) begin
      n_fail++;
      $display("FAIL back_to_back: got update=%b pblk=%h delay=%h, expected 1 a5 00000100",
               update, pulse_block, delay);
    end
    wait_resp();
  endtask

  task automatic test_hold();
    logic unstable = 1'b0;
    tx_ready = 1'b0;
    send_frame(48'h04_00_00_00_20_24, 8'h04);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      rx_data  = 8'hAA;
      rx_valid = (i == 20);
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h04) unstable = 1'b1;
    end
    n_tests++;
    if (unstable) begin
      n_fail++;
      $display("FAIL hold_stable: got tx_valid=%b tx_data=%02h changing, expected steady 1 04", tx_valid, tx_data);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (p2width !== 32'h20) begin
      n_fail++;
      $display("FAIL hold_p2width: got %h, expected 00000020", p2width);
    end
    wait_resp();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({period, p1width, delay, p2width, pulse_block_off, pre_att, post_att, pulse_block, pump, block,
         tx_valid, update} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got period=%h pump=%b tx_valid=%b, expected all 0", period, pump, tx_valid);
    end
    send_frame(48'h08_00_00_12_34_2E, 8'h08);
    wait_resp();
    send_frame(APPLY_FR, 8'h0F);
    @(negedge clk);
    n_tests++;
    if (pulse_block_off !== 32'h1234 || period !== 32'h0 || pump !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got pbo=%h period=%h pump=%b, expected 00001234 0 0",
               pulse_block_off, period, pump);
    end
    wait_resp();
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    test_reset();
    test_period_apply();
    test_narrow();
    test_bad_ck();
    test_bad_op();
    test_timeout();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
